instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage placed directly upstream of the R/I-type decoder. It holds the program counter and issues one word request at a time to instruction memory over a valid/ready request channel plus a response channel. It presents each fetched word and its PC to the decoder on a valid/ready output. It also accepts a PC redirect from later stages and discards any fetch that was in flight when the redirect arrived.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013: value `instr` shows when no valid word is held (addi x0,x0,0).
- clk  input  1  sole clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  permits new requests; does not abort one already issued.
- redirect_valid  input  1  one-cycle PC redirect strobe.
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0 internally.
- imem_req_valid  output  1  request pending.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  word address, equals current PC.
- imem_rsp_valid  input  1  response word present.
- imem_rsp_data  input  32  response word.
- instr_valid  output  1  `instr` / `instr_pc` valid for the decoder.
- instr_ready  input  1  decoder consumes the held word.
- instr  output  32  fetched instruction.
- instr_pc  output  32  PC of `instr`.

## Operation
- FSM with 4 states:
  - IDLE: no request.
  - REQ: `imem_req_valid` = 1.
  - WAIT: one request outstanding.
  - HOLD: `instr_valid` = 1.
- One internal `discard` flag marks an outstanding response that must be dropped.
- IDLE -> REQ when `fetch_en` = 1.
- REQ -> WAIT when `imem_req_ready` = 1. While `imem_req_valid` is high, `imem_addr` is held stable; the only exception is a redirect that is not accepted in the same cycle.
- WAIT, on `imem_rsp_valid`:
  - If `discard` = 0: capture `instr` <= data and `instr_pc` <= pc, set `instr_valid`, update pc <= pc+4, go to HOLD.
  - If `discard` = 1: clear `discard`, go to REQ (or IDLE if `fetch_en` = 0).
- HOLD, on `instr_ready`: clear `instr_valid`, go to REQ (or IDLE if `fetch_en` = 0).
- Redirect has highest priority. New pc = {redirect_pc[31:2],2'b00}.
  - IDLE: load pc, stay in IDLE.
  - REQ without `imem_req_ready`: load pc, stay in REQ; the next cycle's `imem_addr` shows the new PC.
  - REQ with `imem_req_ready` in the same cycle: load pc, set `discard`, go to WAIT.
  - WAIT without `imem_rsp_valid`: load pc, set `discard`, stay in WAIT.
  - WAIT with `imem_rsp_valid` in the same cycle: drop the word, load pc, go to REQ.
  - HOLD: flush by clearing `instr_valid` and setting `instr` to NOP_INSTR, load pc, go to REQ. This applies even when `instr_ready` is asserted in the same cycle; the decoder must not count that word as consumed.
- `imem_rsp_valid` outside WAIT is ignored.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values:
  - state = IDLE, pc = RESET_PC, `discard` = 0.
  - `imem_req_valid` = 0, `imem_addr` = RESET_PC.
  - `instr_valid` = 0, `instr` = NOP_INSTR, `instr_pc` = RESET_PC.
- Reset mid-operation (any state) returns to these values on the next edge. An outstanding response arriving after reset is ignored, because state is IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Minimum latency:
  - `fetch_en` rising -> `imem_req_valid` high on the next cycle.
  - Accept at edge N, response valid at cycle N+1 -> `instr_valid` high from edge N+2.
  - Peak throughput is one instruction per 3 cycles with single-cycle memory and `instr_ready` held high.
- `instr`, `instr_pc` and `instr_valid` stay constant while `instr_valid` = 1 and `instr_ready` = 0, unless a redirect occurs.

## Structure
- Shared package or include: FSM state encodings (2-bit) and the NOP_INSTR constant. Opcode constants 7'b0110011 and 7'b0010011 are placed alongside so fetch and decode share one definition.
- Single module, no sub-module needed. The PC register, FSM, `discard` flag and output register fit comfortably in one block.

## Test plan
- **Reset and first fetch.** Reset, then `fetch_en` = 1, memory always ready, 1-cycle response 32'h0020_8133. Required: `imem_addr` = 0; `instr` = 32'h0020_8133 with `instr_pc` = 0; next `imem_addr` = 4.
- **Backpressure.** Hold `instr_ready` = 0 for 5 cycles in HOLD. Required: `instr`/`instr_pc` stable, no new request issued. Releasing it gives a request to 4 on the next cycle.
- **Redirect while in WAIT.** Redirect to 32'h0000_0103 while in WAIT; stale response 32'hDEAD_BEEF arrives later. Required: stale word never shown; next request to 32'h0000_0100; `instr_pc` = 32'h100.
- **Simultaneous redirect and `instr_ready` in HOLD.** Redirect to 32'h40 in HOLD with `instr_ready` = 1. Required: `instr_valid` = 0 and `instr` = 32'h13 next cycle, then request to 32'h40.
- **PC wrap.** RESET_PC = 32'hFFFF_FFFC, two fetches. Required: `instr_pc` values 32'hFFFF_FFFC then 32'h0000_0000.
- **Reset mid-operation.** Assert `rst` while in WAIT, then deliver a response the cycle after. Required: all reset values restored, response ignored, `instr_valid` stays 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch and decode stages: FSM encodings,
// the canonical NOP and the base opcodes decode keys on.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HOLD = 2'b11
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [6:0]  OPC_R_TYPE  = 7'b0110011;
    localparam logic [6:0]  OPC_I_TYPE  = 7'b0010011;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding word request to instruction
// memory, a held output word for the decoder, and redirect with discard.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, and the payload is held
    // stable while valid is high and no transfer (or redirect) has happened.

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         discard, discard_d;
    logic [31:0]  redirect_tgt;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            discard    <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            discard    <= discard_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        discard_d  = discard;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end else if (fetch_en) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // A request accepted this cycle was for the old PC.
                    if (imem_req_ready) begin
                        discard_d = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_rsp_valid) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (discard) begin
                        discard_d = 1'b0;
                        state_d   = fetch_en ? ST_REQ : ST_IDLE;
                    end else begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc;
                        pc_d       = pc + 32'd4;
                        state_d    = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                // A redirect flushes the held word even if the decoder is
                // ready this cycle; that word does not count as consumed.
                if (redirect_valid) begin
                    instr_d = NOP_INSTR;
                    pc_d    = redirect_tgt;
                    state_d = ST_REQ;
                end else if (instr_ready) begin
                    instr_d = NOP_INSTR;
                    state_d = fetch_en ? ST_REQ : ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req_valid = (state == ST_REQ);
    assign instr_valid    = (state == ST_HOLD);
    assign imem_addr      = pc;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner
// sequences, and randomized traffic against a word-stream reference model.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, fetch_en, redirect_valid, imem_req_ready, imem_rsp_valid, instr_ready;
    logic [31:0] redirect_pc, imem_rsp_data;
    logic        imem_req_valid, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;

    logic        w_rst, w_fetch_en, w_req_ready, w_rsp_valid, w_instr_ready;
    logic [31:0] w_rsp_data;
    logic        w_req_valid, w_instr_valid;
    logic [31:0] w_addr, w_instr, w_instr_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(w_rst), .fetch_en(w_fetch_en),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .instr_valid(w_instr_valid),
        .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        fe, rdy, rsp;
        logic [31:0] data;
        logic        ir, rd;
        logic [31:0] rdpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr, e_ipc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t row(input logic fe, rdy, rsp, input logic [31:0] data,
                                 input logic ir, rd, input logic [31:0] rdpc,
                                 input logic e_rv, input logic [31:0] e_addr,
                                 input logic e_iv, input logic [31:0] e_instr, e_ipc);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rsp = rsp; v.data = data; v.ir = ir; v.rd = rd;
        v.rdpc = rdpc; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_ipc = e_ipc;
        return v;
    endfunction

    // Memory contents: an odd-multiplier hash, so every address holds a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic idle_inputs();
        fetch_en = 0; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; instr_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_addr"},      imem_addr,           32'h0);
        chk({tag, "_instr_valid"}, 32'(instr_valid),  32'd0);
        chk({tag, "_instr"},     instr,               NOP_INSTR);
        chk({tag, "_instr_pc"},  instr_pc,            32'h0);
    endtask

    // Random-phase model state
    logic [31:0] exp_pc, pend_addr, prev_addr;
    logic        pend, prev_hold, accept;
    int          pend_cnt, n_consumed;

    initial begin
        w_rst = 1; w_fetch_en = 0; w_req_ready = 0; w_rsp_valid = 0;
        w_rsp_data = 0; w_instr_ready = 0;
        do_reset();
        chk_reset_vals("reset");

        // fe rdy rsp data ir rd rdpc | rv addr iv instr ipc
        vq.push_back(row(1,1,0,0,0,0,0,            0,32'h0,  0,NOP_INSTR,32'h0));
        vq.push_back(row(1,1,0,0,0,0,0,            1,32'h0,  0,NOP_INSTR,32'h0));
        vq.push_back(row(1,0,1,32'h0020_8133,0,0,0,0,32'h0,  0,NOP_INSTR,32'h0));
        vq.push_back(row(1,1,0,0,0,0,0,            0,32'h4,  1,32'h0020_8133,32'h0));
        vq.push_back(row(1,1,0,0,0,0,0,            0,32'h4,  1,32'h0020_8133,32'h0));
        vq.push_back(row(1,1,1,32'hDEAD_BEEF,0,0,0,0,32'h4,  1,32'h0020_8133,32'h0));
        vq.push_back(row(1,1,0,0,0,0,0,            0,32'h4,  1,32'h0020_8133,32'h0));
        vq.push_back(row(1,1,0,0,0,0,0,            0,32'h4,  1,32'h0020_8133,32'h0));
        vq.push_back(row(1,0,0,0,1,0,0,            0,32'h4,  1,32'h0020_8133,32'h0));
        vq.push_back(row(1,1,0,0,0,0,0,            1,32'h4,  0,NOP_INSTR,32'h0));
        vq.push_back(row(1,0,0,0,0,1,32'h103,      0,32'h4,  0,NOP_INSTR,32'h0));
        vq.push_back(row(1,0,0,0,0,0,0,            0,32'h100,0,NOP_INSTR,32'h0));
        vq.push_back(row(1,0,1,32'hDEAD_BEEF,0,0,0,0,32'h100,0,NOP_INSTR,32'h0));
        vq.push_back(row(1,0,0,0,0,0,0,            1,32'h100,0,NOP_INSTR,32'h0));
        vq.push_back(row(1,1,0,0,0,0,0,            1,32'h100,0,NOP_INSTR,32'h0));
        vq.push_back(row(1,0,1,32'h00A0_0093,0,0,0,0,32'h100,0,NOP_INSTR,32'h0));
        vq.push_back(row(1,0,0,0,1,1,32'h40,       0,32'h104,1,32'h00A0_0093,32'h100));
        vq.push_back(row(0,1,0,0,0,0,0,            1,32'h40, 0,NOP_INSTR,32'h100));
        vq.push_back(row(0,0,1,32'h4000_0033,0,0,0,0,32'h40, 0,NOP_INSTR,32'h100));
        vq.push_back(row(0,0,0,0,1,0,0,            0,32'h44, 1,32'h4000_0033,32'h40));
        vq.push_back(row(0,0,0,0,0,1,32'h207,      0,32'h44, 0,NOP_INSTR,32'h40));
        vq.push_back(row(0,0,0,0,0,0,0,            0,32'h204,0,NOP_INSTR,32'h40));
        vq.push_back(row(1,0,0,0,0,0,0,            0,32'h204,0,NOP_INSTR,32'h40));
        vq.push_back(row(1,0,0,0,0,1,32'h300,      1,32'h204,0,NOP_INSTR,32'h40));
        vq.push_back(row(1,1,0,0,0,1,32'h500,      1,32'h300,0,NOP_INSTR,32'h40));
        vq.push_back(row(1,0,1,32'hBADB_AD00,0,0,0,0,32'h500,0,NOP_INSTR,32'h40));
        vq.push_back(row(1,1,0,0,0,0,0,            1,32'h500,0,NOP_INSTR,32'h40));
        vq.push_back(row(1,0,1,32'h1111_1111,0,1,32'h600,0,32'h500,0,NOP_INSTR,32'h40));
        vq.push_back(row(1,0,0,0,0,0,0,            1,32'h600,0,NOP_INSTR,32'h40));

        foreach (vq[i]) begin
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vq[i].e_rv));
            chk($sformatf("vec%0d_addr", i), imem_addr, vq[i].e_addr);
            chk($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(vq[i].e_iv));
            chk($sformatf("vec%0d_instr", i), instr, vq[i].e_instr);
            chk($sformatf("vec%0d_instr_pc", i), instr_pc, vq[i].e_ipc);
            fetch_en = vq[i].fe; imem_req_ready = vq[i].rdy; imem_rsp_valid = vq[i].rsp;
            imem_rsp_data = vq[i].data; instr_ready = vq[i].ir;
            redirect_valid = vq[i].rd; redirect_pc = vq[i].rdpc;
            @(posedge clk); #1;
        end

        // Reset while a request is outstanding; the late response must be ignored.
        idle_inputs(); fetch_en = 1; imem_req_ready = 1;
        @(posedge clk); #1;
        chk("midrst_in_wait", 32'(imem_req_valid), 32'd0);
        rst = 1; imem_req_ready = 0;
        @(posedge clk); #1;
        rst = 0;
        chk_reset_vals("midrst");
        fetch_en = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        imem_rsp_valid = 0;
        chk_reset_vals("midrst_rsp");
        @(posedge clk); #1;
        chk("midrst_iv_stays", 32'(instr_valid), 32'd0);

        // PC wrap and peak throughput on the second instance.
        begin
            logic        p2;
            logic [31:0] p2_addr;
            logic [31:0] pcs[$];
            int          cyc[$];
            repeat (2) @(posedge clk);
            #1 w_rst = 0;
            chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
            w_fetch_en = 1; w_req_ready = 1; w_instr_ready = 1; p2 = 0; p2_addr = 0;
            for (int c = 0; c < 40 && pcs.size() < 2; c++) begin
                w_rsp_valid = p2; w_rsp_data = p2_addr ^ 32'h1234_0000; p2 = 0;
                if (w_req_valid && w_req_ready) begin p2 = 1; p2_addr = w_addr; end
                if (w_instr_valid) begin
                    chk("wrap_instr", w_instr, w_instr_pc ^ 32'h1234_0000);
                    pcs.push_back(w_instr_pc); cyc.push_back(c);
                end
                @(posedge clk); #1;
            end
            w_rsp_valid = 0; w_fetch_en = 0;
            if (pcs.size() < 2) begin
                n_cmp++; n_fail++;
                $display("FAIL wrap_timeout: got %0d words required 2", pcs.size());
            end else begin
                chk("wrap_pc0", pcs[0], 32'hFFFF_FFFC);
                chk("wrap_pc1", pcs[1], 32'h0000_0000);
                chk("peak_throughput", 32'(cyc[1] - cyc[0]), 32'd3);
            end
        end

        // Randomized traffic: every word the decoder consumes must be the
        // memory word at the next address of the current sequential stream.
        do_reset();
        exp_pc = 0; pend = 0; pend_cnt = 0; pend_addr = 0; prev_hold = 0;
        prev_addr = 0; n_consumed = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!instr_valid) chk("rand_nop_when_empty", instr, NOP_INSTR);
            if (prev_hold) begin
                chk("rand_req_held", 32'(imem_req_valid), 32'd1);
                chk("rand_addr_stable", imem_addr, prev_addr);
            end
            imem_rsp_valid = 0; imem_rsp_data = $urandom;
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1; imem_rsp_data = mem_word(pend_addr); pend = 0;
                end else pend_cnt--;
            end else begin
                imem_rsp_valid = ($urandom_range(0, 9) == 0);
            end
            imem_req_ready = ($urandom_range(0, 2) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            fetch_en       = ($urandom_range(0, 9) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            accept = imem_req_valid && imem_req_ready;
            if (accept) begin
                pend = 1; pend_addr = imem_addr; pend_cnt = $urandom_range(0, 2);
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                chk("rand_instr_pc", instr_pc, exp_pc);
                chk("rand_instr", instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            prev_hold = imem_req_valid && !accept && !redirect_valid;
            prev_addr = imem_addr;
            @(posedge clk); #1;
        end
        idle_inputs();
        n_cmp++;
        if (n_consumed < 200) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d words required at least 200", n_consumed);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
